// File: rtl/ram_rr_arbiter_pkg.sv
// Shared constants and helpers for the RAM round-robin arbiter.
// Latency: n/a (types and combinational functions only).
// Backpressure: n/a.
package ram_arb_pkg;

    localparam int ARB_MAX_REQ = 8;
    localparam int ARB_PTR_W   = 3;

    // Ceiling log2 for constant width calculations.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

    // Index width for NUM_REQ requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // One-hot round-robin pick: first asserted req at or after ptr, wrapping at n.
    function automatic logic [ARB_MAX_REQ-1:0] rr_pick(
        input logic [ARB_MAX_REQ-1:0] req,
        input logic [ARB_PTR_W-1:0]   ptr,
        input logic [ARB_PTR_W:0]     n
    );
        logic [ARB_MAX_REQ-1:0] g;
        logic                   found;
        logic [ARB_PTR_W:0]     sum;
        logic [ARB_PTR_W-1:0]   pos;
        g     = '0;
        found = 1'b0;
        for (int i = 0; i < ARB_MAX_REQ; i++) begin
            sum = {1'b0, ptr} + (ARB_PTR_W+1)'(i);
            pos = (sum >= n) ? ARB_PTR_W'(sum - n) : sum[ARB_PTR_W-1:0];
            if (!found && ((ARB_PTR_W+1)'(i) < n) && req[pos]) begin
                g[pos] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/ram_rr_arbiter_if.sv
// Requester-side and RAM-side bus of the shared-RAM arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req/we/addr/wdata until gnt.
interface ram_rr_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int COL_WIDTH  = 8,
    parameter int NB_COL     = 4
);
    localparam int DW = NB_COL * COL_WIDTH;

    logic [NUM_REQ-1:0]            req_i;
    logic [NUM_REQ*NB_COL-1:0]     we_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i;
    logic [NUM_REQ*DW-1:0]         wdata_i;
    logic [NUM_REQ-1:0]            gnt_o;
    logic [NUM_REQ-1:0]            rvalid_o;
    logic                          err_o;
    logic [DW-1:0]                 rdata_o;
    logic [NB_COL-1:0]             ram_we_o;
    logic [ADDR_WIDTH-1:0]         ram_addr_o;
    logic [DW-1:0]                 ram_di_o;
    logic [DW-1:0]                 ram_dout_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, ram_dout_i,
        output gnt_o, rvalid_o, err_o, rdata_o, ram_we_o, ram_addr_o, ram_di_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, ram_dout_i,
        input  gnt_o, rvalid_o, err_o, rdata_o, ram_we_o, ram_addr_o, ram_di_o
    );

endinterface

// File: rtl/ram_rr_arbiter_core.sv
// Round-robin grant generator with internal rotating priority pointer.
// Latency: grant is combinational in the request cycle.
// Backpressure: ungranted requesters simply wait; pointer moves past each winner.
module rr_arbiter_core
    import ram_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IW      = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    assign gnt = NUM_REQ'(rr_pick(ARB_MAX_REQ'(req), ARB_PTR_W'(ptr_q),
                                  (ARB_PTR_W+1)'(NUM_REQ)));

    // Encode the one-hot grant; zero when nothing is granted.
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) idx = IW'(i);
        end
    end

    // Priority moves to the slot just after the winner, wrapping at NUM_REQ.
    always_comb begin
        ptr_d = ptr_q;
        if (|gnt) ptr_d = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    end

    // Pointer register; requester 0 has top priority out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Shares one single-port read-first byte-write RAM among NUM_REQ requesters.
// Latency: grant same cycle, response (rvalid/rdata/err) one cycle after grant.
// Backpressure: one access per cycle; losers hold their request until granted.
module ram_rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int SIZE       = 1024,
    parameter int ADDR_WIDTH = 32,
    parameter int COL_WIDTH  = 8,
    parameter int NB_COL     = 4
) (
    input logic               clk,
    input logic               rstn,
    ram_rr_arbiter_if.slave   bus
);

    localparam int DW = NB_COL * COL_WIDTH;
    localparam int IW = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]    gnt;
    logic [IW-1:0]         idx;
    logic                  any_gnt;
    logic [NB_COL-1:0]     sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DW-1:0]         sel_di;
    logic [63:0]           word;
    logic                  in_range;
    logic                  pend_q;
    logic                  oor_q;
    logic [IW-1:0]         owner_q;
    logic [NUM_REQ-1:0]    rvalid;

    rr_arbiter_core #(.NUM_REQ(NUM_REQ)) u_core (
        .clk  (clk),
        .rstn (rstn),
        .req  (bus.req_i),
        .gnt  (gnt),
        .idx  (idx)
    );

    assign any_gnt   = |gnt;
    assign bus.gnt_o = gnt;

    // Select the winner's access fields; idle bus drives zeros.
    always_comb begin
        sel_we   = '0;
        sel_addr = '0;
        sel_di   = '0;
        if (any_gnt) begin
            sel_we   = bus.we_i[int'(idx)*NB_COL +: NB_COL];
            sel_addr = bus.addr_i[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH];
            sel_di   = bus.wdata_i[int'(idx)*DW +: DW];
        end
    end

    // Word index compared at 64 bits so high address bits are never dropped.
    always_comb begin
        word     = 64'(sel_addr >> 2);
        in_range = (word < 64'(SIZE));
    end

    // Out-of-range writes must not reach the RAM; the read is harmless.
    assign bus.ram_we_o   = in_range ? sel_we : '0;
    assign bus.ram_addr_o = sel_addr;
    assign bus.ram_di_o   = sel_di;

    // Remember who owns the RAM output next cycle and whether it was rejected.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q  <= 1'b0;
            oor_q   <= 1'b0;
            owner_q <= '0;
        end else begin
            pend_q  <= any_gnt;
            oor_q   <= any_gnt && !in_range;
            owner_q <= idx;
        end
    end

    // Route the response strobe back to the owner as a one-hot vector.
    always_comb begin
        rvalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rvalid[i] = pend_q && (owner_q == IW'(i));
        end
    end

    assign bus.rvalid_o = rvalid;
    assign bus.err_o    = pend_q && oor_q;
    assign bus.rdata_o  = (pend_q && oor_q) ? '0 : bus.ram_dout_i;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: directed scenarios plus random traffic vs a reference model.
// Latency: n/a.
// Backpressure: random requesters hold fields until granted.
module tb_ram_rr_arbiter;

    localparam int N    = 3;
    localparam int SIZE = 1024;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem       [SIZE];
    logic [31:0] model_mem [SIZE];

    int          m_ptr  = 0;
    bit          m_pend = 0;
    int          m_own  = 0;
    bit          m_err  = 0;
    logic [31:0] m_data = '0;

    logic [2:0] seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    ram_rr_arbiter_if #(.NUM_REQ(N)) bus ();

    ram_rr_arbiter #(.NUM_REQ(N), .SIZE(SIZE)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Byte-write read-first RAM with one cycle read latency.
    always @(posedge clk) begin
        bus.ram_dout_i <= mem[bus.ram_addr_o[11:2]];
        for (int b = 0; b < 4; b++) begin
            if (bus.ram_we_o[b]) mem[bus.ram_addr_o[11:2]][b*8 +: 8] <= bus.ram_di_o[b*8 +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pick, access, response and memory derived from the rules.
    always @(negedge clk) begin
        int          k;
        int          j;
        logic [2:0]  eg;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] w;
        logic [3:0]  we;
        logic [3:0]  ewe;
        bit          oor;
        if (!rstn) m_ptr = 0;
        k = -1;
        for (int i = 0; i < N; i++) begin
            j = (m_ptr + i) % N;
            if (k < 0 && bus.req_i[j]) k = j;
        end
        eg = '0; a = '0; d = '0; w = '0; we = '0; ewe = '0; oor = 0;
        if (k >= 0) begin
            eg[k] = 1'b1;
            a     = bus.addr_i[k*32 +: 32];
            d     = bus.wdata_i[k*32 +: 32];
            we    = bus.we_i[k*4 +: 4];
            w     = a >> 2;
            oor   = (w >= SIZE);
            ewe   = oor ? 4'b0 : we;
        end
        chk("gnt", 32'(bus.gnt_o), 32'(eg));
        chk("ram_we", 32'(bus.ram_we_o), 32'(ewe));
        chk("ram_addr", bus.ram_addr_o, a);
        chk("ram_di", bus.ram_di_o, d);
        if (!rstn) begin
            chk("rvalid_rst", 32'(bus.rvalid_o), 32'd0);
            chk("err_rst", 32'(bus.err_o), 32'd0);
            m_pend = 0;
        end else begin
            chk("rvalid", 32'(bus.rvalid_o), m_pend ? (32'd1 << m_own) : 32'd0);
            if (m_pend) begin
                chk("err", 32'(bus.err_o), 32'(m_err));
                chk("rdata", bus.rdata_o, m_data);
            end else begin
                chk("err_idle", 32'(bus.err_o), 32'd0);
            end
            m_pend = (k >= 0);
            if (k >= 0) begin
                m_own  = k;
                m_err  = oor;
                m_data = oor ? 32'd0 : model_mem[w[9:0]];
                m_ptr  = (k + 1) % N;
            end
        end
        if (k >= 0 && !oor) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) model_mem[w[9:0]][b*8 +: 8] = d[b*8 +: 8];
            end
        end
    end

    task automatic clr();
        bus.req_i   = '0;
        bus.we_i    = '0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
    endtask

    task automatic set_port(input int p, input logic r, input logic [3:0] w,
                            input logic [31:0] a, input logic [31:0] d);
        bus.req_i[p]           = r;
        bus.we_i[p*4 +: 4]     = w;
        bus.addr_i[p*32 +: 32] = a;
        bus.wdata_i[p*32 +: 32] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] g;
        int           r;
        for (int i = 0; i < SIZE; i++) begin
            mem[i]       = '0;
            model_mem[i] = '0;
        end
        bus.ram_dout_i = '0;
        clr();
        for (int p = 0; p < N; p++) set_port(p, 1'b1, 4'h0, 32'h0, 32'h0);

        // Reset with all requesting
        repeat (2) begin
            @(negedge clk);
            chk("t1_gnt_in_reset", 32'(bus.gnt_o), 32'b001);
            chk("t1_rvalid_in_reset", 32'(bus.rvalid_o), 32'b000);
            chk("t1_err_in_reset", 32'(bus.err_o), 32'd0);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Fairness with all three holding requests
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t2_gnt_seq", 32'(bus.gnt_o), 32'(seq[i]));
            if (i > 0) chk("t2_rvalid_seq", 32'(bus.rvalid_o), 32'(seq[i-1]));
            tick();
        end
        clr();
        @(negedge clk);
        chk("t2_rvalid_last", 32'(bus.rvalid_o), 32'b100);
        tick();

        // Byte-lane merge
        clr(); set_port(1, 1'b1, 4'hF, 32'h10, 32'hAABBCCDD);
        @(negedge clk); chk("t3_gnt_p1", 32'(bus.gnt_o), 32'b010); tick();
        clr(); set_port(0, 1'b1, 4'b0010, 32'h10, 32'h00001100);
        @(negedge clk); chk("t3_gnt_p0", 32'(bus.gnt_o), 32'b001); tick();
        clr(); set_port(2, 1'b1, 4'h0, 32'h10, 32'h0);
        @(negedge clk); chk("t3_gnt_p2", 32'(bus.gnt_o), 32'b100); tick();
        clr();
        @(negedge clk);
        chk("t3_rvalid", 32'(bus.rvalid_o), 32'b100);
        chk("t3_rdata", bus.rdata_o, 32'hAABB11DD);
        tick();

        // Read-first write acknowledge
        clr(); set_port(0, 1'b1, 4'hF, 32'h20, 32'hDEADBEEF); tick();
        clr(); set_port(1, 1'b1, 4'hF, 32'h20, 32'h12345678); tick();
        clr(); set_port(2, 1'b1, 4'h0, 32'h20, 32'h0);
        @(negedge clk);
        chk("t4_ack_rvalid", 32'(bus.rvalid_o), 32'b010);
        chk("t4_ack_rdata", bus.rdata_o, 32'hDEADBEEF);
        tick();
        clr();
        @(negedge clk);
        chk("t4_rd_rvalid", 32'(bus.rvalid_o), 32'b100);
        chk("t4_rd_rdata", bus.rdata_o, 32'h12345678);
        tick();

        // Out-of-range write must not alias onto word 0
        clr(); set_port(0, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D); tick();
        clr(); set_port(2, 1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF);
        @(negedge clk);
        chk("t5_gnt", 32'(bus.gnt_o), 32'b100);
        chk("t5_ram_we", 32'(bus.ram_we_o), 32'd0);
        tick();
        clr(); set_port(0, 1'b1, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t5_rvalid", 32'(bus.rvalid_o), 32'b100);
        chk("t5_err", 32'(bus.err_o), 32'd1);
        chk("t5_rdata", bus.rdata_o, 32'd0);
        tick();
        clr();
        @(negedge clk);
        chk("t5_w0_rvalid", 32'(bus.rvalid_o), 32'b001);
        chk("t5_w0_err", 32'(bus.err_o), 32'd0);
        chk("t5_w0_rdata", bus.rdata_o, 32'hCAFEF00D);
        tick();

        // Reset while a response is pending
        clr(); set_port(1, 1'b1, 4'h0, 32'h10, 32'h0);
        @(negedge clk);
        chk("t6_gnt_p1", 32'(bus.gnt_o), 32'b010);
        #1;
        rstn = 1'b0;
        clr();
        tick();
        @(negedge clk);
        chk("t6_rvalid_dropped", 32'(bus.rvalid_o), 32'b000);
        chk("t6_err_dropped", 32'(bus.err_o), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int p = 0; p < N; p++) set_port(p, 1'b1, 4'h0, 32'h10, 32'h0);
        @(negedge clk);
        chk("t6_gnt_ptr0", 32'(bus.gnt_o), 32'b001);
        chk("t6_rvalid_after", 32'(bus.rvalid_o), 32'b000);
        tick();
        clr();
        tick();

        // Random traffic; each requester holds its fields until granted
        g = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int p = 0; p < N; p++) begin
                if (bus.req_i[p] && !g[p]) begin
                    if ($urandom_range(0, 15) == 0) bus.req_i[p] = 1'b0;
                end else begin
                    r = $urandom_range(0, 9);
                    set_port(p, ($urandom_range(0, 3) != 0),
                             ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0,
                             (r == 0) ? 32'(((1024 + $urandom_range(0, 7)) << 2) + $urandom_range(0, 3)) :
                             (r == 1) ? 32'hFFFF_FFF0 :
                                        32'(($urandom_range(0, 15) << 2) + $urandom_range(0, 3)),
                             $urandom);
                end
            end
            @(negedge clk);
            g = bus.gnt_o;
            tick();
        end
        clr();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
